bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter for the multi-digit seven-segment display path.
//  Converts an unsigned DATA_W-bit value plus an optional half-unit flag into DIGITS BCD digits.
//  Uses iterative double-dabble, one bit per clock, in place of combinational dividers.
//  A per-digit select mux feeds the display scanner directly. Code 10 is the blank code.
// PARAMETERS
//  DATA_W  8  width of unsigned binary input, >=1
//  DIGITS  3  number of integer BCD digits produced, >=1
//  SEL_W   $clog2(DIGITS+2)  width of digit select, >=1 (derived; do not override)
// PORTS
//  clk         in   1           rising-edge clock
//  reset       in   1           synchronous, active-low
//  start       in   1           request conversion; accepted only when ready=1
//  data        in   DATA_W      unsigned value, sampled on accepted start
//  half        in   1           fraction flag (+0.5), sampled on accepted start
//  ready       out  1           converter idle, can accept start
//  done        out  1           one-cycle pulse, result registers just updated
//  bcd         out  4*DIGITS    result; nibble k = 10^k digit (k=0 is units)
//  frac_digit  out  4           tenths digit: 5 if half else 0
//  overflow    out  1           value >= 10^DIGITS, valid with/after done
//  select      in   SEL_W       display digit select
//  digit       out  4           selected digit (combinational from registered results)
// BEHAVIOUR
//  Reset (reset=0 at a clk edge): FSM->IDLE; ready=1, done=0, bcd=0, frac_digit=0, overflow=0.
//   Shift and counter registers are cleared.
//  While reset=0, digit=0 regardless of select (combinational override).
//  FSM states IDLE, SHIFT, DONE:
//   IDLE: ready=1. On start=1, latch data into shift reg, latch half, clear BCD accumulator.
//    Also clear the overflow accumulator, load cnt=DATA_W-1, go to SHIFT.
//   SHIFT: ready=0. Each cycle, apply the add-3 step to every accumulator nibble >=5.
//    Then shift {acc,shreg} left by 1. A 1 shifted out of acc MSB sets the sticky overflow accumulator.
//    When cnt==0 go to DONE, else cnt--. The state runs exactly DATA_W cycles.
//   DONE: ready=0. Register the results: bcd=acc, frac_digit=half?5:0, overflow=sticky.
//    If sticky=1, bcd is loaded as all nibbles 4'd9 (saturate). Assert done for this cycle only.
//    Then go to IDLE.
//  Latency: start accepted at edge N -> done=1 and new bcd visible after edge N+DATA_W+1.
//   Throughput is one conversion per DATA_W+2 cycles.
//  start while ready=0 is ignored (no queueing). data and half may change freely after acceptance.
//  bcd, frac_digit and overflow hold their values between done pulses. They are not cleared at start.
//  Reset mid-SHIFT or in DONE: conversion aborted, no done pulse, outputs take their reset values.
//  digit mux: select=0 -> 4'd10 (blank); 1 -> frac_digit; 2..DIGITS+1 -> bcd nibble select-2.
//   Any other select value -> 4'd0.
//  Arithmetic: acc width 4*DIGITS. The add-3 step is applied before the shift, on all nibbles in parallel.
//   No X or undefined states: unused FSM encodings recover to IDLE.
// TESTING (default DATA_W=8, DIGITS=3 unless noted)
//  T1: reset, then start with data=8'd255, half=0.
//   -> done after 9 edges; bcd=12'h255, overflow=0, frac_digit=0.
//   -> select sweep 0..4 gives digit 10,0,5,5,2; select 5..7 gives 0.
//  T2: data=0, half=1 -> bcd=12'h000, frac_digit=5.
//   data=8'd9 -> bcd=12'h009. data=8'd100 -> bcd=12'h100.
//  T3: DIGITS=2, data=8'd100 -> overflow=1, bcd=8'h99.
//   Then data=8'd99 -> overflow=0, bcd=8'h99.
//  T4: start data=8'd42, pulse start with data=8'd7 during SHIFT and during DONE
//   -> both ignored, single done, bcd=12'h042.
//   Start asserted the cycle after done is accepted -> back-to-back result correct.
//  T5: start data=8'd200, drive reset=0 on the 4th SHIFT cycle
//   -> no done pulse, ready=1, bcd=0; digit=0 while reset low.
//   A following conversion of 8'd37 gives bcd=12'h037.
//  T6: DATA_W=16, DIGITS=5, data=16'd65535 -> done after 17 edges, bcd=20'h65535.
//   Random sweep of data checked against a reference model, 1000 vectors.

Source files
------------

// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: start/result/display-select bundle for the sequential BCD converter
interface bin_to_bcd_seq_if #(
   parameter int DATA_W = 8,
   parameter int DIGITS = 3
);
   localparam int SEL_W = $clog2(DIGITS + 2);
   logic                start;
   logic [DATA_W-1:0]   data;
   logic                half;
   logic                ready;
   logic                done;
   logic [4*DIGITS-1:0] bcd;
   logic [3:0]          frac_digit;
   logic                overflow;
   logic [SEL_W-1:0]    select;
   logic [3:0]          digit;
   modport master (output start, data, half, select,
                   input  ready, done, bcd, frac_digit, overflow, digit);
   modport slave  (input  start, data, half, select,
                   output ready, done, bcd, frac_digit, overflow, digit);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-bit-per-clock double-dabble converter with a saturating result and display digit mux
module bin_to_bcd_seq #(
   parameter int DATA_W = 8,
   parameter int DIGITS = 3
) (
   input logic                clk,
   input logic                reset,
   bin_to_bcd_seq_if.slave    bus
);
   localparam int SEL_W = $clog2(DIGITS + 2);
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t              state_q;
   logic                ready_q, done_q, half_q, sticky_q, ovf_q, sticky_d;
   logic [DATA_W-1:0]   sh_q, sh_d;
   logic [4*DIGITS-1:0] acc_q, acc_d, adj, bcd_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [3:0]          frac_q, dig;
   // add-3 on every nibble >=5, then shift {acc,shreg}; the bit leaving acc marks overflow
   always_comb begin
      adj = acc_q;
      for (int k = 0; k < DIGITS; k++)
         if (acc_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      acc_d    = {adj[4*DIGITS-2:0], sh_q[DATA_W-1]};
      sticky_d = sticky_q | adj[4*DIGITS-1];
      sh_d     = sh_q << 1;
   end
   // control FSM with registered handshake and result outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         bcd_q    <= '0;
         frac_q   <= '0;
         ovf_q    <= 1'b0;
         acc_q    <= '0;
         sh_q     <= '0;
         cnt_q    <= '0;
         half_q   <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (bus.start) begin
               sh_q     <= bus.data;
               half_q   <= bus.half;
               acc_q    <= '0;
               sticky_q <= 1'b0;
               cnt_q    <= CNT_W'(DATA_W - 1);
               ready_q  <= 1'b0;
               state_q  <= SHIFT;
            end
            SHIFT: begin
               acc_q    <= acc_d;
               sh_q     <= sh_d;
               sticky_q <= sticky_d;
               if (cnt_q == '0) state_q <= DONE;
               else cnt_q <= cnt_q - CNT_W'(1);
            end
            DONE: begin
               bcd_q   <= sticky_q ? {DIGITS{4'd9}} : acc_q;
               frac_q  <= half_q ? 4'd5 : 4'd0;
               ovf_q   <= sticky_q;
               done_q  <= 1'b1;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end
   // display mux: 0 blank, 1 tenths, 2.. integer digits from units up; forced to 0 in reset
   always_comb begin
      dig = 4'd0;
      if (reset) begin
         if (bus.select == '0) dig = 4'd10;
         else if (bus.select == SEL_W'(1)) dig = frac_q;
         for (int k = 0; k < DIGITS; k++)
            if (bus.select == SEL_W'(k + 2)) dig = bcd_q[4*k +: 4];
      end
   end
   assign bus.ready      = ready_q;
   assign bus.done       = done_q;
   assign bus.bcd        = bcd_q;
   assign bus.frac_digit = frac_q;
   assign bus.overflow   = ovf_q;
   assign bus.digit      = dig;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed checks of the BCD converter in three parameterisations
module tb_bin_to_bcd_seq;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   always #5 clk = ~clk;
   bin_to_bcd_seq_if #(.DATA_W(8),  .DIGITS(3)) b0 ();
   bin_to_bcd_seq_if #(.DATA_W(8),  .DIGITS(2)) b1 ();
   bin_to_bcd_seq_if #(.DATA_W(16), .DIGITS(5)) b2 ();
   bin_to_bcd_seq #(.DATA_W(8),  .DIGITS(3)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
   bin_to_bcd_seq #(.DATA_W(8),  .DIGITS(2)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
   bin_to_bcd_seq #(.DATA_W(16), .DIGITS(5)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));

   task automatic go0(input logic [7:0] d, input logic h, output int lat);
      @(negedge clk); b0.start = 1'b1; b0.data = d; b0.half = h;
      @(negedge clk); b0.start = 1'b0; b0.data = ~d; b0.half = ~h; lat = 0;
      while (!b0.done && lat < 40) begin @(negedge clk); lat++; end
   endtask

   task automatic go1(input logic [7:0] d, output int lat);
      @(negedge clk); b1.start = 1'b1; b1.data = d;
      @(negedge clk); b1.start = 1'b0; b1.data = ~d; lat = 0;
      while (!b1.done && lat < 40) begin @(negedge clk); lat++; end
   endtask

   task automatic go2(input logic [15:0] d, output int lat);
      @(negedge clk); b2.start = 1'b1; b2.data = d;
      @(negedge clk); b2.start = 1'b0; b2.data = ~d; lat = 0;
      while (!b2.done && lat < 60) begin @(negedge clk); lat++; end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      b0.select = '0;
      #1;
      n_vec++; if (b0.ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", b0.ready); end
      n_vec++; if (b0.done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", b0.done); end
      n_vec++; if (b0.bcd !== 12'h000 || b0.frac_digit !== 4'd0 || b0.overflow !== 1'b0) begin
         n_err++; $display("FAIL rst_outputs got %h/%0d/%b want 000/0/0", b0.bcd, b0.frac_digit, b0.overflow); end
      n_vec++; if (b0.digit !== 4'd0) begin n_err++; $display("FAIL rst_digit got %0d want 0", b0.digit); end
      reset = 1'b1;
      @(negedge clk); #1;
      n_vec++; if (b0.digit !== 4'd10) begin n_err++; $display("FAIL blank_digit got %0d want 10", b0.digit); end
   endtask

   task automatic test_basic;
      int lat;
      logic [3:0] exp_d [8] = '{4'd10, 4'd0, 4'd5, 4'd5, 4'd2, 4'd0, 4'd0, 4'd0};
      go0(8'd255, 1'b0, lat);
      n_vec++; if (lat !== 9) begin n_err++; $display("FAIL t1_latency got %0d want 9", lat); end
      n_vec++; if (b0.bcd !== 12'h255) begin n_err++; $display("FAIL t1_bcd got %h want 255", b0.bcd); end
      n_vec++; if (b0.overflow !== 1'b0 || b0.frac_digit !== 4'd0) begin
         n_err++; $display("FAIL t1_ovf_frac got %b/%0d want 0/0", b0.overflow, b0.frac_digit); end
      @(negedge clk);
      n_vec++; if (b0.done !== 1'b0 || b0.ready !== 1'b1) begin
         n_err++; $display("FAIL t1_pulse done/ready got %b/%b want 0/1", b0.done, b0.ready); end
      for (int s = 0; s < 8; s++) begin
         b0.select = 3'(s); #1;
         n_vec++; if (b0.digit !== exp_d[s]) begin n_err++; $display("FAIL t1_sel%0d got %0d want %0d", s, b0.digit, exp_d[s]); end
      end
      b0.select = '0;
   endtask

   task automatic test_values;
      int lat;
      go0(8'd0, 1'b1, lat);
      n_vec++; if (b0.bcd !== 12'h000 || b0.frac_digit !== 4'd5) begin
         n_err++; $display("FAIL t2_zero_half got %h/%0d want 000/5", b0.bcd, b0.frac_digit); end
      b0.select = 3'd1; #1;
      n_vec++; if (b0.digit !== 4'd5) begin n_err++; $display("FAIL t2_frac_sel got %0d want 5", b0.digit); end
      go0(8'd9, 1'b0, lat);
      n_vec++; if (b0.bcd !== 12'h009 || b0.frac_digit !== 4'd0) begin
         n_err++; $display("FAIL t2_nine got %h/%0d want 009/0", b0.bcd, b0.frac_digit); end
      go0(8'd100, 1'b0, lat);
      n_vec++; if (b0.bcd !== 12'h100) begin n_err++; $display("FAIL t2_hundred got %h want 100", b0.bcd); end
      b0.select = '0;
   endtask

   task automatic test_saturate;
      int lat;
      go1(8'd100, lat);
      n_vec++; if (b1.overflow !== 1'b1 || b1.bcd !== 8'h99) begin
         n_err++; $display("FAIL t3_ovf100 got %b/%h want 1/99", b1.overflow, b1.bcd); end
      go1(8'd99, lat);
      n_vec++; if (b1.overflow !== 1'b0 || b1.bcd !== 8'h99) begin
         n_err++; $display("FAIL t3_99 got %b/%h want 0/99", b1.overflow, b1.bcd); end
      go1(8'd255, lat);
      n_vec++; if (b1.overflow !== 1'b1 || b1.bcd !== 8'h99) begin
         n_err++; $display("FAIL t3_ovf255 got %b/%h want 1/99", b1.overflow, b1.bcd); end
   endtask

   task automatic test_ignore;
      int ndone;
      logic [11:0] got;
      ndone = 0; got = '0;
      @(negedge clk); b0.start = 1'b1; b0.data = 8'd42; b0.half = 1'b0;
      @(negedge clk); b0.start = 1'b0; b0.data = 8'd7;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 3 || i == 8) b0.start = 1'b1;
         if (i == 4 || i == 9) b0.start = 1'b0;
         if (b0.done) begin ndone++; got = b0.bcd; end
      end
      n_vec++; if (ndone !== 1) begin n_err++; $display("FAIL t4_done_count got %0d want 1", ndone); end
      n_vec++; if (got !== 12'h042) begin n_err++; $display("FAIL t4_bcd got %h want 042", got); end
      n_vec++; if (b0.ready !== 1'b1) begin n_err++; $display("FAIL t4_idle_ready got %b want 1", b0.ready); end
   endtask

   task automatic test_back_to_back;
      int lat;
      @(negedge clk); b0.start = 1'b1; b0.data = 8'd200;
      @(negedge clk); b0.start = 1'b0; lat = 0;
      while (!b0.done && lat < 40) begin @(negedge clk); lat++; end
      n_vec++; if (lat !== 9 || b0.bcd !== 12'h200) begin
         n_err++; $display("FAIL b2b_first got lat %0d bcd %h want 9/200", lat, b0.bcd); end
      b0.start = 1'b1; b0.data = 8'd37;
      @(negedge clk); b0.start = 1'b0; b0.data = 8'd0; lat = 0;
      while (!b0.done && lat < 40) begin @(negedge clk); lat++; end
      n_vec++; if (lat !== 9 || b0.bcd !== 12'h037) begin
         n_err++; $display("FAIL b2b_second got lat %0d bcd %h want 9/037", lat, b0.bcd); end
   endtask

   task automatic test_reset_abort;
      int lat, seen;
      @(negedge clk); b0.start = 1'b1; b0.data = 8'd200;
      @(negedge clk); b0.start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0; b0.select = 3'd2; #1;
      n_vec++; if (b0.digit !== 4'd0) begin n_err++; $display("FAIL t5_digit_override got %0d want 0", b0.digit); end
      @(negedge clk);
      n_vec++; if (b0.ready !== 1'b1 || b0.bcd !== 12'h000 || b0.done !== 1'b0) begin
         n_err++; $display("FAIL t5_abort got ready %b bcd %h done %b want 1/000/0", b0.ready, b0.bcd, b0.done); end
      reset = 1'b1; seen = 0;
      repeat (15) begin @(negedge clk); if (b0.done) seen++; end
      n_vec++; if (seen !== 0) begin n_err++; $display("FAIL t5_no_done got %0d want 0", seen); end
      b0.select = '0;
      go0(8'd37, 1'b0, lat);
      n_vec++; if (lat !== 9 || b0.bcd !== 12'h037) begin
         n_err++; $display("FAIL t5_after got lat %0d bcd %h want 9/037", lat, b0.bcd); end
   endtask

   task automatic test_wide;
      int lat, v;
      logic [15:0] d;
      logic [19:0] exp_b;
      go2(16'd65535, lat);
      n_vec++; if (lat !== 17 || b2.bcd !== 20'h65535 || b2.overflow !== 1'b0) begin
         n_err++; $display("FAIL t6_max got lat %0d bcd %h ovf %b want 17/65535/0", lat, b2.bcd, b2.overflow); end
      for (int n = 0; n < 1000; n++) begin
         d = 16'($urandom_range(0, 65535));
         v = int'(d);
         for (int k = 0; k < 5; k++) begin exp_b[4*k +: 4] = 4'(v % 10); v = v / 10; end
         go2(d, lat);
         n_vec++; if (b2.bcd !== exp_b || lat !== 17) begin
            n_err++; $display("FAIL t6_rand data %0d got %h lat %0d want %h/17", d, b2.bcd, lat, exp_b); end
      end
   endtask

   initial begin
      b0.start = 1'b0; b0.data = '0; b0.half = 1'b0; b0.select = '0;
      b1.start = 1'b0; b1.data = '0; b1.half = 1'b0; b1.select = '0;
      b2.start = 1'b0; b2.data = '0; b2.half = 1'b0; b2.select = '0;
      test_reset;
      test_basic;
      test_values;
      test_saturate;
      test_ignore;
      test_back_to_back;
      test_reset_abort;
      test_wide;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
